// File: rtl/router_1x3.sv
// One-input, three-output word router: each valid word is steered by addr to a
// registered output port, with per-port delivery counters and an invalid-address drop counter.
module router_1x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] data_out   [3],
  output logic                  valid_out  [3],
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  pkt_count  [3],
  output logic [CNT_WIDTH-1:0]  drop_count
);

  // Handshake: valid-only, no ready. Every cycle with valid_in = 1 is accepted;
  // data_in/addr are ignored (may be X) whenever valid_in = 0.
  localparam logic [1:0] ADDR_BAD = 2'b11;

  logic [2:0] port_hit;
  logic       bad_hit;
  logic       drop_full;

  always_comb begin
    port_hit = '0;
    for (int k = 0; k < 3; k++) begin
      port_hit[k] = valid_in && (addr == 2'(k));
    end
    bad_hit   = valid_in && (addr == ADDR_BAD);
    drop_full = &drop_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        data_out[k]  <= '0;
        valid_out[k] <= 1'b0;
        pkt_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        valid_out[k] <= port_hit[k];
        // Data only moves on a hit, so X on data_in in idle cycles never lands here.
        if (port_hit[k]) begin
          data_out[k]  <= data_in;
          pkt_count[k] <= pkt_count[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Drop counter saturates rather than wraps so a long fault burst stays visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err        <= 1'b0;
      drop_count <= '0;
    end else begin
      err <= bad_hit;
      if (bad_hit && !drop_full) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_1x3.sv
// Self-checking bench for router_1x3: driver tasks push expected deliveries into a
// scoreboard queue; a negedge monitor pops and checks them against a reference model.
module tb_router_1x3;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic [1:0] addr;
  logic [7:0] data_out  [3];
  logic       valid_out [3];
  logic       err;
  logic [7:0] pkt_count [3];
  logic [7:0] drop_count;

  router_1x3 #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .addr       (addr),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .err        (err),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];   // {port, data}; port 3 = dropped word (data ignored)
  int         due_q[$];   // cycle at which the matching strobe must appear
  logic [7:0] m_data [3];
  logic [7:0] m_cnt  [3];
  logic [7:0] m_drop;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    for (int k = 0; k < 3; k++) begin
      m_data[k] = 8'h00;
      m_cnt[k]  = 8'h00;
    end
    m_drop = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_data"}, 32'(data_out[k]), 32'h0);
      check({tag, "_valid"}, 32'(valid_out[k]), 32'h0);
      check({tag, "_cnt"}, 32'(pkt_count[k]), 32'h0);
    end
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_drop"}, 32'(drop_count), 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    addr     = a;
    data_in  = d;
    exp_q.push_back({a, (a == 2'b11) ? 8'h00 : d});
    due_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      addr     = 2'($urandom_range(0, 3));
      data_in  = 8'($urandom);
    end
  endtask

  // Asserts reset between clock edges, checks outputs clear without a clock edge.
  task automatic async_reset(input int hold_cycles);
    @(posedge clk);
    #3;
    rst = 1'b0;
    valid_in = 1'b1;
    model_clear();
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'($urandom_range(0, 1));
      addr     = 2'($urandom_range(0, 3));
      data_in  = 8'($urandom);
    end
    rst = 1'b1;
    valid_in = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0] obs_vec;
    logic [3:0] exp_vec;
    logic [9:0] e;
    obs_vec = {err, valid_out[2], valid_out[1], valid_out[0]};
    if (!rst) begin
      check("in_reset_strobe", 32'(obs_vec), 32'h0);
      check("in_reset_drop", 32'(drop_count), 32'h0);
    end else begin
      check("onehot", 32'($countones(obs_vec) > 1), 32'h0);
      exp_vec = 4'b0000;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        e = exp_q.pop_front();
        exp_vec = (e[9:8] == 2'b11) ? 4'b1000 : 4'(1 << e[9:8]);
        if (e[9:8] == 2'b11) begin
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end else begin
          m_data[e[9:8]] = e[7:0];
          m_cnt[e[9:8]]  = m_cnt[e[9:8]] + 8'd1;
        end
      end
      check("strobe", 32'(obs_vec), 32'(exp_vec));
      for (int k = 0; k < 3; k++) begin
        check("data_out", {22'd0, 2'(k), data_out[k]}, {22'd0, 2'(k), m_data[k]});
        check("pkt_count", {22'd0, 2'(k), pkt_count[k]}, {22'd0, 2'(k), m_cnt[k]});
      end
      check("drop_count", 32'(drop_count), 32'(m_drop));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    addr     = 2'b00;
    data_in  = 8'h00;
    model_clear();

    // 1. reset held two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'($urandom_range(0, 1));
      addr     = 2'($urandom_range(0, 3));
      data_in  = 8'($urandom);
    end
    check_all_zero("reset");
    rst = 1'b1;
    valid_in = 1'b0;
    idle(1);

    // 2. single routes
    send(2'b00, 8'hAA);
    idle(1);
    send(2'b01, 8'hBB);
    idle(1);
    send(2'b10, 8'hCC);
    idle(2);
    check("route_p0", 32'(data_out[0]), 32'hAA);
    check("route_p1", 32'(data_out[1]), 32'hBB);
    check("route_p2", 32'(data_out[2]), 32'hCC);
    for (int k = 0; k < 3; k++) check("route_cnt", 32'(pkt_count[k]), 32'd1);

    // 3. invalid address
    send(2'b11, 8'hDD);
    idle(2);
    check("bad_drop", 32'(drop_count), 32'd1);
    check("bad_p0_hold", 32'(data_out[0]), 32'hAA);

    // 4. back-to-back to port 1
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b01, 8'h33);
    idle(2);
    check("b2b_data", 32'(data_out[1]), 32'h33);
    check("b2b_cnt", 32'(pkt_count[1]), 32'd4);

    // 5. wrap and saturation from a clean state
    async_reset(2);
    idle(1);
    for (int i = 0; i < 256; i++) send(2'b10, 8'($urandom));
    idle(2);
    check("wrap_cnt", 32'(pkt_count[2]), 32'd0);
    for (int i = 0; i < 300; i++) send(2'b11, 8'($urandom));
    idle(2);
    check("sat_drop", 32'(drop_count), 32'hFF);

    // random mixed traffic with idle gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(2'($urandom_range(0, 3)), 8'($urandom));
    end
    idle(2);

    // 6. async reset mid-stream with a word in flight
    send(2'b00, 8'h77);
    async_reset(2);
    idle(1);
    send(2'b00, 8'h5A);
    idle(2);
    check("post_rst_data", 32'(data_out[0]), 32'h5A);
    check("post_rst_cnt", 32'(pkt_count[0]), 32'd1);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
